// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, counter widths and the sync-detector state type.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } sync_state_e;

    // 640x480@60 profile at a 50 MHz pixel-side clock
    localparam int H_TOTAL_DEF      = 1600;
    localparam int H_TOL_DEF        = 8;
    localparam int V_LINES_DEF      = 521;
    localparam int V_TOL_DEF        = 1;
    localparam int LOCK_FRAMES_DEF  = 2;
    localparam int MISS_MAX_DEF     = 2;
    localparam int H_SYNC_PW        = 192;
    localparam int V_SYNC_PW_LINES  = 2;

    localparam int HCNT_W = 12;
    localparam int LCNT_W = 10;
    localparam int FCNT_W = 4;

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [LCNT_W-1:0] LCNT_MAX = '1;

endpackage

// File: rtl/sync_edge_sync.sv
// Two-flop synchronizer for an active-low async sync pin, plus a registered
// falling-edge pulse three clocks after the pin falls.
module sync_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic fall_q;

    // Idle level of a sync line is high, so preset the chain to 1 to avoid a
    // spurious edge right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= sync_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            fall_q <= prev_q & ~sync_q;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/vga_sync_detector.sv
// Measures incoming HSYNC/VSYNC timing and declares lock on the expected profile.
// Optional VGA_SYNC_POS_EN adds h_pos/v_pos position outputs.
module vga_sync_detector
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL     = H_TOTAL_DEF,
    parameter int H_TOL       = H_TOL_DEF,
    parameter int V_LINES     = V_LINES_DEF,
    parameter int V_TOL       = V_TOL_DEF,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
    parameter int MISS_MAX    = MISS_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic              locked,
    output logic [HCNT_W-1:0] line_len,
    output logic [LCNT_W-1:0] frame_lines,
    output logic              line_strobe,
    output logic              frame_strobe,
    output logic              sync_error
`ifdef VGA_SYNC_POS_EN
    ,
    output logic [HCNT_W-1:0] h_pos,
    output logic [LCNT_W-1:0] v_pos
`endif
);

    localparam logic [HCNT_W-1:0] H_MIN  = HCNT_W'(H_TOTAL - H_TOL);
    localparam logic [HCNT_W-1:0] H_MAX  = HCNT_W'(H_TOTAL + H_TOL);
    localparam logic [LCNT_W-1:0] L_MIN  = LCNT_W'(V_LINES - V_TOL);
    localparam logic [LCNT_W-1:0] L_MAX  = LCNT_W'(V_LINES + V_TOL);
    localparam logic [FCNT_W-1:0] GOOD_T = FCNT_W'(LOCK_FRAMES);
    localparam logic [FCNT_W-1:0] MISS_T = FCNT_W'(MISS_MAX);

    logic h_edge;
    logic v_edge;

    sync_edge_sync u_hsync (.clk(clk), .reset(reset), .sync_i(hsync_in), .fall_o(h_edge));
    sync_edge_sync u_vsync (.clk(clk), .reset(reset), .sync_i(vsync_in), .fall_o(v_edge));

    sync_state_e       state_q, state_d;
    logic [HCNT_W-1:0] h_cnt_q, h_cnt_d, line_len_q, line_len_d;
    logic [LCNT_W-1:0] l_cnt_q, l_cnt_d, frame_lines_q, frame_lines_d;
    logic [FCNT_W-1:0] good_cnt_q, good_cnt_d, miss_cnt_q, miss_cnt_d;
    logic              h_valid_q, h_valid_d;
    logic              frame_bad_q, frame_bad_d;
    logic              locked_q, locked_d;
    logic              sync_error_q, sync_error_d;
    logic              line_strobe_q, frame_strobe_q;

    logic              timeout;
    logic              line_bad;
    logic [LCNT_W-1:0] l_cnt_inc;
    logic              bad_inc;
    logic              frame_good;

    // A coincident hsync edge belongs to the frame that the vsync edge closes.
    assign timeout    = (h_cnt_q == HCNT_MAX) && !h_edge;
    assign line_bad   = h_valid_q && ((h_cnt_q < H_MIN) || (h_cnt_q > H_MAX));
    assign l_cnt_inc  = (h_edge && (l_cnt_q != LCNT_MAX)) ? l_cnt_q + 1'b1 : l_cnt_q;
    assign bad_inc    = frame_bad_q | (h_edge & line_bad);
    assign frame_good = !bad_inc && (l_cnt_inc >= L_MIN) && (l_cnt_inc <= L_MAX);

    always_comb begin
        state_d       = state_q;
        h_cnt_d       = h_cnt_q;
        line_len_d    = line_len_q;
        l_cnt_d       = l_cnt_inc;
        frame_lines_d = frame_lines_q;
        good_cnt_d    = good_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        h_valid_d     = h_valid_q;
        frame_bad_d   = bad_inc;
        sync_error_d  = 1'b0;

        if (h_edge) begin
            h_cnt_d    = HCNT_W'(1);
            line_len_d = h_cnt_q;
            h_valid_d  = 1'b1;
        end else if (h_cnt_q != HCNT_MAX) begin
            h_cnt_d = h_cnt_q + 1'b1;
        end

        if (v_edge) begin
            frame_lines_d = l_cnt_inc;
            l_cnt_d       = '0;
            frame_bad_d   = 1'b0;
            case (state_q)
                SEARCH: begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                end
                MEASURE: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 1'b1;
                        if (good_cnt_q + 1'b1 == GOOD_T) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (frame_good) begin
                        miss_cnt_d = '0;
                    end else if (miss_cnt_q + 1'b1 == MISS_T) begin
                        state_d      = MEASURE;
                        good_cnt_d   = '0;
                        miss_cnt_d   = '0;
                        sync_error_d = 1'b1;
                    end else begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // A stalled line counter overrides any frame decision.
        if (timeout) begin
            state_d      = SEARCH;
            h_valid_d    = 1'b0;
            sync_error_d = locked_q;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= SEARCH;
            h_cnt_q        <= '0;
            line_len_q     <= '0;
            l_cnt_q        <= '0;
            frame_lines_q  <= '0;
            good_cnt_q     <= '0;
            miss_cnt_q     <= '0;
            h_valid_q      <= 1'b0;
            frame_bad_q    <= 1'b0;
            locked_q       <= 1'b0;
            sync_error_q   <= 1'b0;
            line_strobe_q  <= 1'b0;
            frame_strobe_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            h_cnt_q        <= h_cnt_d;
            line_len_q     <= line_len_d;
            l_cnt_q        <= l_cnt_d;
            frame_lines_q  <= frame_lines_d;
            good_cnt_q     <= good_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            h_valid_q      <= h_valid_d;
            frame_bad_q    <= frame_bad_d;
            locked_q       <= locked_d;
            sync_error_q   <= sync_error_d;
            line_strobe_q  <= h_edge;
            frame_strobe_q <= v_edge;
        end
    end

    assign locked       = locked_q;
    assign line_len     = line_len_q;
    assign frame_lines  = frame_lines_q;
    assign line_strobe  = line_strobe_q;
    assign frame_strobe = frame_strobe_q;
    assign sync_error   = sync_error_q;

`ifdef VGA_SYNC_POS_EN
    assign h_pos = locked_q ? h_cnt_q : '0;
    assign v_pos = locked_q ? l_cnt_q : '0;
`endif

endmodule
